// File: rtl/br_pkg.sv
// Shared encodings for the branch-condition controller: condition codes, FSM states,
// ALU control values and flag-register bit positions.
package br_pkg;

  typedef enum logic [2:0] {
    COND_EQ     = 3'd0,
    COND_NE     = 3'd1,
    COND_LT     = 3'd2,
    COND_GT     = 3'd3,
    COND_LE     = 3'd4,
    COND_GE     = 3'd5,
    COND_ALWAYS = 3'd6,
    COND_OVF    = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_EVAL  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b1110;
  localparam logic [3:0] ALU_SUB = 4'b1101;

  localparam int FLG_EQ  = 0;
  localparam int FLG_LT  = 1;
  localparam int FLG_GT  = 2;
  localparam int FLG_LE  = 3;
  localparam int FLG_GE  = 4;
  localparam int FLG_NE  = 5;
  localparam int FLG_OVF = 6;
  localparam int FLG_FV  = 7;

  // Raw flag bit selected by a condition; ALWAYS and the fv qualification are handled by the caller.
  function automatic logic cond_sel(input cond_e cond, input logic [7:0] fr);
    logic bit_sel;
    case (cond)
      COND_EQ:  bit_sel = fr[FLG_EQ];
      COND_NE:  bit_sel = fr[FLG_NE];
      COND_LT:  bit_sel = fr[FLG_LT];
      COND_GT:  bit_sel = fr[FLG_GT];
      COND_LE:  bit_sel = fr[FLG_LE];
      COND_GE:  bit_sel = fr[FLG_GE];
      COND_OVF: bit_sel = fr[FLG_OVF];
      default:  bit_sel = 1'b0;
    endcase
    return bit_sel;
  endfunction

endpackage

// File: rtl/branch_cond_ctrl_condcodes.sv
// Signed condition codes derived from an add/sub result; a signed overflow clears every code
// because the result sign no longer reflects the true comparison.
module condcodes
  import br_pkg::*;
(
  input  logic [3:0]  aluctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] aluout,
  output logic        eq,
  output logic        ne,
  output logic        lt,
  output logic        gt,
  output logic        le,
  output logic        ge
);

  logic ovf;
  logic zero;
  logic neg;

  always_comb begin
    ovf = 1'b0;
    if (aluctrl == ALU_ADD) begin
      ovf = (a[31] == b[31]) & (aluout[31] != a[31]);
    end else if (aluctrl == ALU_SUB) begin
      ovf = (a[31] != b[31]) & (aluout[31] != a[31]);
    end
    zero = (aluout == 32'd0);
    neg  = aluout[31];
    eq   = ~ovf & zero;
    ne   = ~ovf & ~zero;
    lt   = ~ovf & neg;
    gt   = ~ovf & ~neg & ~zero;
    le   = ~ovf & (neg | zero);
    ge   = ~ovf & ~neg;
  end

endmodule

// File: rtl/branch_cond_ctrl.sv
// Flags register plus branch sequencer: resolves ID branch requests against the latched flags
// and drives stall, redirect and flush toward the front end.
module branch_cond_ctrl
  import br_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2  // legal range 1..7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_setcc,
  input  logic        ex_busy,
  input  logic [3:0]  ex_aluctrl,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic [31:0] ex_aluout,
  input  logic        br_req,
  input  logic [2:0]  br_cond,
  input  logic [31:0] br_target,
  output logic        br_ack,
  output logic        br_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        stall,
  output logic        flush,
  output logic [7:0]  flags_q
);

  state_e      state_reg, state_next;
  logic [2:0]  cnt_reg;
  cond_e       cond_reg;
  logic [31:0] target_reg;
  logic [7:0]  flags_reg;

  logic cc_eq, cc_ne, cc_lt, cc_gt, cc_le, cc_ge;
  logic fr_we;
  logic taken;

  condcodes u_condcodes (
    .aluctrl (ex_aluctrl),
    .a       (ex_a),
    .b       (ex_b),
    .aluout  (ex_aluout),
    .eq      (cc_eq),
    .ne      (cc_ne),
    .lt      (cc_lt),
    .gt      (cc_gt),
    .le      (cc_le),
    .ge      (cc_ge)
  );

  assign fr_we = ex_valid & ex_setcc & ~ex_busy;
  assign taken = (cond_reg == COND_ALWAYS) | (flags_reg[FLG_FV] & cond_sel(cond_reg, flags_reg));

  // Flags register; ovf is recovered from the fact that overflow zeroes both EQ and NE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_reg <= 8'd0;
    end else if (fr_we) begin
      flags_reg <= {1'b1, ~(cc_eq | cc_ne), cc_ne, cc_ge, cc_le, cc_gt, cc_lt, cc_eq};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cond_reg   <= COND_EQ;
      target_reg <= 32'd0;
      cnt_reg    <= 3'd0;
    end else begin
      if (state_reg == ST_IDLE && br_req) begin
        cond_reg   <= cond_e'(br_cond);
        target_reg <= br_target;
      end
      if (state_reg == ST_EVAL && taken) begin
        cnt_reg <= 3'(FLUSH_CYCLES - 1);
      end else if (state_reg == ST_FLUSH && cnt_reg != 3'd0) begin
        cnt_reg <= cnt_reg - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (br_req) state_next = ex_busy ? ST_HOLD : ST_EVAL;
      end
      ST_HOLD: begin
        if (!ex_busy) state_next = ST_EVAL;
      end
      ST_EVAL: begin
        state_next = taken ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        if (cnt_reg == 3'd0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    br_ack         = (state_reg == ST_EVAL);
    br_taken       = br_ack & taken;
    redirect_valid = br_ack & taken;
    flush          = (state_reg == ST_FLUSH);
    stall          = (state_reg != ST_IDLE) | br_req;
    redirect_pc    = target_reg;
    flags_q        = flags_reg;
  end

endmodule

// File: tb/tb_branch_cond_ctrl.sv
// Directed bench for branch_cond_ctrl: stimulus queues expected branch outcomes and flush
// lengths, and an independent monitor checks them as the DUT presents acks and flush runs.
module tb_branch_cond_ctrl;
  import br_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_setcc, ex_busy;
  logic [3:0]  ex_aluctrl;
  logic [31:0] ex_a, ex_b, ex_aluout;
  logic        br_req;
  logic [2:0]  br_cond;
  logic [31:0] br_target;
  logic        br_ack, br_taken, redirect_valid, stall, flush;
  logic [31:0] redirect_pc;
  logic [7:0]  flags_q;

  typedef struct {
    bit          taken;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   flush_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_cond_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_setcc       (ex_setcc),
    .ex_busy        (ex_busy),
    .ex_aluctrl     (ex_aluctrl),
    .ex_a           (ex_a),
    .ex_b           (ex_b),
    .ex_aluout      (ex_aluout),
    .br_req         (br_req),
    .br_cond        (br_cond),
    .br_target      (br_target),
    .br_ack         (br_ack),
    .br_taken       (br_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .flush          (flush),
    .flags_q        (flags_q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one line per resolved branch; flush runs are measured when flush falls.
  initial begin
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (br_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack, expected none");
        end else begin
          e = exp_q.pop_front();
          $display("branch ack: taken=%0b redirect_valid=%0b pc=0x%0h", br_taken, redirect_valid, redirect_pc);
          check("br_taken", 32'(br_taken), 32'(e.taken));
          check("redirect_valid", 32'(redirect_valid), 32'(e.taken));
          if (e.taken) check("redirect_pc", redirect_pc, e.pc);
        end
      end
      if (flush) begin
        run++;
      end else if (run > 0) begin
        if (flush_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flush: got %0d cycles, expected none", run);
        end else begin
          check("flush_len", 32'(run), 32'(flush_q.pop_front()));
        end
        run = 0;
      end
    end
  end

  task automatic wait_ack(input int exp_wait);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (br_ack) seen = 1;
      else check("stall_while_pending", 32'(stall), 32'd1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack in 20 cycles, expected ack");
    end else begin
      check("ack_latency", 32'(n), 32'(exp_wait));
    end
    @(posedge clk); #1;
    br_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((stall || flush) && n < 20) begin
      if (flush) check("stall_during_flush", 32'(stall), 32'd1);
      @(negedge clk);
      n++;
    end
    check("returns_idle", 32'(stall | flush), 32'd0);
  endtask

  task automatic issue(input logic [2:0] cond, input logic [31:0] target, input bit exp_taken);
    exp_q.push_back('{taken: exp_taken, pc: target});
    if (exp_taken) flush_q.push_back(2);
    @(posedge clk); #1;
    br_req    = 1'b1;
    br_cond   = cond;
    br_target = target;
    wait_ack(2);
    wait_idle();
  endtask

  task automatic setcc(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] out, input logic [7:0] exp_flags);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_setcc = 1'b1; ex_aluctrl = ctrl;
    ex_a = a; ex_b = b; ex_aluout = out;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_setcc = 1'b0;
    @(negedge clk);
    $display("setcc: ctrl=%b a=0x%0h b=0x%0h out=0x%0h flags=0x%0h", ctrl, a, b, out, flags_q);
    check("flags_q", 32'(flags_q), 32'(exp_flags));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_setcc = 1'b0; ex_busy = 1'b0; ex_aluctrl = 4'd0;
    ex_a = 32'd0; ex_b = 32'd0; ex_aluout = 32'd0;
    br_req = 1'b0; br_cond = 3'd0; br_target = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_flags", 32'(flags_q), 32'h0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_ack", 32'(br_ack), 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'h0);

    // Right after reset fv=0: conditional not taken, ALWAYS taken.
    issue(3'(COND_LT), 32'h0000_0040, 1'b0);
    issue(3'(COND_ALWAYS), 32'h0000_0400, 1'b1);

    // sub 5-5 -> EQ|LE|GE with fv.
    setcc(ALU_SUB, 32'd5, 32'd5, 32'd0, 8'h99);
    issue(3'(COND_EQ), 32'h0000_0100, 1'b1);

    // add overflow -> only fv and ovf.
    setcc(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 8'hC0);
    issue(3'(COND_OVF), 32'h0000_0200, 1'b1);
    issue(3'(COND_EQ), 32'h0000_0210, 1'b0);
    issue(3'(COND_LT), 32'h0000_0220, 1'b0);
    issue(3'(COND_GE), 32'h0000_0230, 1'b0);

    // NE request while EX busy for 3 cycles; flags written as busy drops (9-4) must be used.
    exp_q.push_back('{taken: 1'b1, pc: 32'h0000_0300});
    flush_q.push_back(2);
    @(posedge clk); #1;
    ex_busy = 1'b1; ex_valid = 1'b1; ex_setcc = 1'b1; ex_aluctrl = ALU_SUB;
    ex_a = 32'd9; ex_b = 32'd4; ex_aluout = 32'd5;
    br_req = 1'b1; br_cond = 3'(COND_NE); br_target = 32'h0000_0300;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_stall", 32'(stall), 32'd1);
      check("busy_no_ack", 32'(br_ack), 32'd0);
      @(posedge clk); #1;
    end
    ex_busy = 1'b0;
    @(negedge clk);
    check("busy_drop_no_ack", 32'(br_ack), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_setcc = 1'b0;
    wait_ack(1);
    wait_idle();
    check("busy_flags", 32'(flags_q), 32'hB4);

    // Same-cycle setcc (3-7, LT) with LT request; EQ setcc during EVAL must not affect it.
    exp_q.push_back('{taken: 1'b1, pc: 32'h0000_0700});
    flush_q.push_back(2);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_setcc = 1'b1; ex_aluctrl = ALU_SUB;
    ex_a = 32'd3; ex_b = 32'd7; ex_aluout = 32'hFFFF_FFFC;
    br_req = 1'b1; br_cond = 3'(COND_LT); br_target = 32'h0000_0700;
    @(posedge clk); #1;
    ex_a = 32'd5; ex_b = 32'd5; ex_aluout = 32'd0;
    @(negedge clk);
    check("eval_ack", 32'(br_ack), 32'd1);
    @(posedge clk); #1;
    br_req = 1'b0; ex_valid = 1'b0; ex_setcc = 1'b0;
    wait_idle();
    check("eval_write_flags", 32'(flags_q), 32'h99);

    // Reset during FLUSH cuts it to one cycle and clears everything.
    exp_q.push_back('{taken: 1'b1, pc: 32'h0000_0500});
    flush_q.push_back(1);
    @(posedge clk); #1;
    br_req = 1'b1; br_cond = 3'(COND_ALWAYS); br_target = 32'h0000_0500;
    wait_ack(2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_ack", 32'(br_ack), 32'd0);
    check("rst_flags", 32'(flags_q), 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    issue(3'(COND_EQ), 32'h0000_0510, 1'b0);
    issue(3'(COND_ALWAYS), 32'h0000_0600, 1'b1);

    repeat (4) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("flush_q_drained", 32'(flush_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
